ibex_multdiv_issue: RTL and testbench

Initiator for the fast multiply/divide unit. It accepts a decoded M-extension request over valid/ready and captures the operands. It then drives the unit's enable, select and operand inputs until the unit reports `valid`, and hands the result to writeback over valid/ready. It also owns the resources the unit borrows: the two 34-bit intermediate-value registers and the shared 33-bit operand adder with its zero detect.

---
 rtl/ibex_multdiv_pkg.sv | 29 ++
 rtl/ibex_multdiv_adder.sv | 17 +
 rtl/ibex_multdiv_issue.sv | 164 ++++++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_multdiv_pkg.sv
// Shared types for the multiply/divide issue block.
package ibex_multdiv_pkg;

    localparam int IMD_W = 34;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } issue_state_e;

    // Request fields held for the whole operation.
    typedef struct packed {
        md_op_e      operator;
        logic [1:0]  signed_mode;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        data_ind_timing;
    } md_req_t;

endpackage

// File: rtl/ibex_multdiv_adder.sv
// Shared 33-bit operand adder lent to the multdiv unit, with zero detect.
module ibex_multdiv_adder (
    input  logic [32:0] operand_a_i,
    input  logic [32:0] operand_b_i,
    output logic [33:0] adder_ext_o,
    output logic [31:0] adder_o,
    output logic        equal_to_zero_o
);

    // Zero-extend both operands so the carry out lands in bit 33.
    always_comb begin
        adder_ext_o     = {1'b0, operand_a_i} + {1'b0, operand_b_i};
        adder_o         = adder_ext_o[32:1];
        equal_to_zero_o = (adder_o == 32'd0);
    end

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue/initiator for the fast multdiv unit: accepts a request, keeps the
// unit enabled until it reports valid, then presents the result to writeback.
module ibex_multdiv_issue
    import ibex_multdiv_pkg::*;
#(
    parameter int RV32M = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic [4:0]  req_rd_i,
    input  logic        data_ind_timing_i,
    input  logic        flush_i,

    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic        data_ind_timing_o,

    input  logic [32:0] alu_operand_a_i,
    input  logic [32:0] alu_operand_b_i,
    output logic [33:0] alu_adder_ext_o,
    output logic [31:0] alu_adder_o,
    output logic        equal_to_zero_o,

    input  logic [67:0] imd_val_d_i,
    input  logic [1:0]  imd_val_we_i,
    output logic [67:0] imd_val_q_o,

    output logic        multdiv_ready_id_o,
    input  logic [31:0] multdiv_result_i,
    input  logic        valid_i,

    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o
);

    // The multiplier flavour only changes the unit's latency, not this block.
    logic unused_rv32m;
    assign unused_rv32m = (RV32M == 2);

    issue_state_e     state_q, state_d;
    md_req_t          req_q, req_d;
    logic             flush_pending_q, flush_pending_d;
    logic [31:0]      wb_data_q;
    logic [IMD_W-1:0] imd_hi_q, imd_lo_q;
    logic             accept, wb_load, busy, is_div;

    ibex_multdiv_adder u_adder (
        .operand_a_i     (alu_operand_a_i),
        .operand_b_i     (alu_operand_b_i),
        .adder_ext_o     (alu_adder_ext_o),
        .adder_o         (alu_adder_o),
        .equal_to_zero_o (equal_to_zero_o)
    );

    // Next-state logic. A flush during BUSY is only remembered: the unit must
    // run to completion, and its result is then dropped instead of written back.
    always_comb begin
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        accept          = 1'b0;
        wb_load         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) flush_pending_d = 1'b1;
                if (valid_i) begin
                    wb_load = 1'b1;
                    // A flush arriving with valid_i kills the result too.
                    if (flush_pending_q || flush_i) begin
                        state_d         = IDLE;
                        flush_pending_d = 1'b0;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                if (wb_ready_i || flush_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture source: the incoming fields, as one record.
    always_comb begin
        req_d                 = req_q;
        if (accept) begin
            req_d.operator        = md_op_e'(req_operator_i);
            req_d.signed_mode     = req_signed_mode_i;
            req_d.op_a            = req_op_a_i;
            req_d.op_b            = req_op_b_i;
            req_d.rd              = req_rd_i;
            req_d.data_ind_timing = data_ind_timing_i;
        end
    end

    // State, held request, pending flush and writeback data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            req_q           <= '0;
            flush_pending_q <= 1'b0;
            wb_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            flush_pending_q <= flush_pending_d;
            if (wb_load) wb_data_q <= multdiv_result_i;
        end
    end

    // Intermediate-value registers borrowed by the unit; writable in any state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imd_hi_q <= '0;
            imd_lo_q <= '0;
        end else begin
            if (imd_val_we_i[0]) imd_hi_q <= imd_val_d_i[2*IMD_W-1:IMD_W];
            if (imd_val_we_i[1]) imd_lo_q <= imd_val_d_i[IMD_W-1:0];
        end
    end

    // Unit control and handshake outputs, all decoded from the current state.
    always_comb begin
        busy               = (state_q == BUSY);
        is_div             = req_q.operator[1];
        req_ready_o        = (state_q == IDLE);
        mult_en_o          = busy & ~is_div;
        mult_sel_o         = busy & ~is_div;
        div_en_o           = busy & is_div;
        div_sel_o          = busy & is_div;
        multdiv_ready_id_o = busy;
        wb_valid_o         = (state_q == WB);
        operator_o         = req_q.operator;
        signed_mode_o      = req_q.signed_mode;
        op_a_o             = req_q.op_a;
        op_b_o             = req_q.op_b;
        data_ind_timing_o  = req_q.data_ind_timing;
        wb_rd_o            = req_q.rd;
        wb_data_o          = wb_data_q;
        imd_val_q_o        = {imd_hi_q, imd_lo_q};
    end

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Self-checking bench for ibex_multdiv_issue. The bench plays the multdiv
// unit: it computes results arithmetically and raises valid_i after the
// expected number of enable cycles.
module tb_ibex_multdiv_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [1:0]  req_operator_i, req_signed_mode_i;
    logic [31:0] req_op_a_i, req_op_b_i;
    logic [4:0]  req_rd_i;
    logic        data_ind_timing_i, flush_i;
    logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    logic [1:0]  operator_o, signed_mode_o;
    logic [31:0] op_a_o, op_b_o;
    logic        data_ind_timing_o;
    logic [32:0] alu_operand_a_i, alu_operand_b_i;
    logic [33:0] alu_adder_ext_o;
    logic [31:0] alu_adder_o;
    logic        equal_to_zero_o;
    logic [67:0] imd_val_d_i, imd_val_q_o;
    logic [1:0]  imd_val_we_i;
    logic        multdiv_ready_id_o;
    logic [31:0] multdiv_result_i;
    logic        valid_i;
    logic        wb_valid_o, wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;
    logic [67:0] imd_m = '0;

    always #5 clk_i = ~clk_i;

    ibex_multdiv_issue #(.RV32M(2)) dut (
        .clk_i, .rst_ni,
        .req_valid_i, .req_ready_o, .req_operator_i, .req_signed_mode_i,
        .req_op_a_i, .req_op_b_i, .req_rd_i, .data_ind_timing_i, .flush_i,
        .mult_en_o, .div_en_o, .mult_sel_o, .div_sel_o,
        .operator_o, .signed_mode_o, .op_a_o, .op_b_o, .data_ind_timing_o,
        .alu_operand_a_i, .alu_operand_b_i, .alu_adder_ext_o, .alu_adder_o,
        .equal_to_zero_o,
        .imd_val_d_i, .imd_val_we_i, .imd_val_q_o,
        .multdiv_ready_id_o, .multdiv_result_i, .valid_i,
        .wb_valid_o, .wb_ready_i, .wb_rd_o, .wb_data_o
    );

    // RV32M semantics with wide signed arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] sm,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] xa, xb, r;
        xa = sm[0] ? {{34{a[31]}}, a} : {34'd0, a};
        xb = sm[1] ? {{34{b[31]}}, b} : {34'd0, b};
        case (op)
            2'd0: begin r = xa * xb; return r[31:0]; end
            2'd1: begin r = xa * xb; return r[63:32]; end
            2'd2: begin if (b == 0) return 32'hFFFFFFFF; r = xa / xb; return r[31:0]; end
            default: begin if (b == 0) return a; r = xa % xb; return r[31:0]; end
        endcase
    endfunction

    // Enable cycles the fast unit needs.
    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b, input logic dit);
        if (op == 2'd0) return 3;
        if (op == 2'd1) return 4;
        return (b == 0 && !dit) ? 2 : 37;
    endfunction

    // Unit model: counts enable cycles, raises valid_i on the last one.
    int en_cnt;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) en_cnt <= 0;
        else if ((mult_en_o || div_en_o) && !valid_i) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
    end

    always_comb begin
        valid_i = (mult_en_o || div_en_o) &&
                  (en_cnt == ref_lat(operator_o, op_b_o, data_ind_timing_o) - 1);
        multdiv_result_i = ref_result(operator_o, signed_mode_o, op_a_o, op_b_o);
    end

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic dit,
                          input logic [31:0] exp, input int exp_en, input int stall,
                          input bit flush_wb);
        int cyc, en_seen;
        bit ctl_ok, got, stall_ok;
        @(negedge clk_i);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1; req_operator_i = op; req_signed_mode_i = sm;
        req_op_a_i = a; req_op_b_i = b; req_rd_i = rd; data_ind_timing_i = dit;
        @(posedge clk_i); #1;
        req_valid_i = 0; req_op_a_i = $urandom; req_op_b_i = $urandom;
        cyc = 0; en_seen = 0; ctl_ok = 1; got = 0;
        while (cyc < 100 && !got) begin
            @(negedge clk_i); cyc++;
            if (wb_valid_o) got = 1;
            else begin
                if (mult_en_o || div_en_o) en_seen++;
                if (mult_en_o != !op[1] || mult_sel_o != !op[1] || div_en_o != op[1] ||
                    div_sel_o != op[1] || !multdiv_ready_id_o || req_ready_o ||
                    operator_o != op || signed_mode_o != sm || op_a_o != a ||
                    op_b_o != b || data_ind_timing_o != dit)
                    ctl_ok = 0;
            end
        end
        chk("wb_valid_seen", got, 1);
        if (!got) return;
        chk("busy_ctl", ctl_ok, 1);
        chk("en_cycles", en_seen, exp_en);
        chk("latency", cyc, exp_en + 1);
        chk("wb_data", wb_data_o, exp);
        chk("wb_rd", wb_rd_o, rd);
        chk("wb_ctl", {multdiv_ready_id_o, mult_en_o, div_en_o, req_ready_o}, 4'b0000);
        stall_ok = 1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            if (!wb_valid_o || wb_data_o != exp || wb_rd_o != rd || req_ready_o ||
                mult_en_o || div_en_o)
                stall_ok = 0;
        end
        if (stall > 0) chk("wb_stall_hold", stall_ok, 1);
        if (flush_wb) flush_i = 1; else wb_ready_i = 1;
        @(posedge clk_i); #1;
        flush_i = 0; wb_ready_i = 0;
        @(negedge clk_i);
        chk("back_idle", {req_ready_o, wb_valid_o}, 2'b10);
    endtask

    task automatic imd_write(input logic [67:0] d, input logic [1:0] we);
        @(negedge clk_i);
        imd_val_d_i = d; imd_val_we_i = we;
        @(posedge clk_i); #1;
        imd_val_we_i = 2'b00;
        if (we[0]) imd_m[67:34] = d[67:34];
        if (we[1]) imd_m[33:0]  = d[33:0];
        chk("imd_q", imd_val_q_o, imd_m);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sm;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        logic [31:0] exp;
        int          en;
    } vec_t;

    vec_t vecs[13];
    logic [32:0] add_a[4];
    logic [32:0] add_b[4];

    initial begin
        int cyc, en_seen;
        bit saw_wb;
        logic [33:0] s;
        logic [1:0]  rop, rsm;
        logic [31:0] ra, rb;
        logic        rdit;

        vecs[0]  = '{2'd0, 2'd0, 32'd7,        32'hFFFFFFFD, 1'b0, 32'hFFFFFFEB, 3};
        vecs[1]  = '{2'd1, 2'd3, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 4};
        vecs[2]  = '{2'd1, 2'd0, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 4};
        vecs[3]  = '{2'd1, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4};
        vecs[4]  = '{2'd1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 4};
        vecs[5]  = '{2'd2, 2'd0, 32'd100,      32'd7,        1'b0, 32'd14,       37};
        vecs[6]  = '{2'd3, 2'd0, 32'd100,      32'd7,        1'b0, 32'd2,        37};
        vecs[7]  = '{2'd2, 2'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 37};
        vecs[8]  = '{2'd3, 2'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 37};
        vecs[9]  = '{2'd2, 2'd0, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 2};
        vecs[10] = '{2'd3, 2'd0, 32'd5,        32'd0,        1'b0, 32'd5,        2};
        vecs[11] = '{2'd2, 2'd0, 32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 37};
        vecs[12] = '{2'd3, 2'd0, 32'd5,        32'd0,        1'b1, 32'd5,        37};
        add_a = '{33'd0, 33'h1FFFFFFFF, 33'h100000000, 33'd1};
        add_b = '{33'd0, 33'd1,         33'h100000000, 33'd0};

        rst_ni = 0; req_valid_i = 0; req_operator_i = 0; req_signed_mode_i = 0;
        req_op_a_i = 0; req_op_b_i = 0; req_rd_i = 0; data_ind_timing_i = 0;
        flush_i = 0; alu_operand_a_i = 0; alu_operand_b_i = 0;
        imd_val_d_i = 0; imd_val_we_i = 0; wb_ready_i = 0;
        repeat (2) @(negedge clk_i);

        // Reset state
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_ctl", {mult_en_o, div_en_o, mult_sel_o, div_sel_o, multdiv_ready_id_o, wb_valid_o}, 6'd0);
        chk("rst_held", {operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o}, 68'd0);
        chk("rst_wb", {wb_rd_o, wb_data_o}, 37'd0);
        chk("rst_imd", imd_val_q_o, 68'd0);
        rst_ni = 1;

        // Adder: corner table then random
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_i);
            if (i < 4) begin alu_operand_a_i = add_a[i]; alu_operand_b_i = add_b[i]; end
            else begin
                alu_operand_a_i = {1'($urandom), $urandom};
                alu_operand_b_i = {1'($urandom), $urandom};
            end
            #1;
            s = 34'(alu_operand_a_i) + 34'(alu_operand_b_i);
            chk("adder_ext", alu_adder_ext_o, s);
            chk("adder", alu_adder_o, s[32:1]);
            chk("adder_zero", equal_to_zero_o, s[32:1] == 32'd0);
        end

        // Intermediate registers: each half, both, neither
        imd_write({4'($urandom), $urandom, $urandom}, 2'b01);
        imd_write({4'($urandom), $urandom, $urandom}, 2'b10);
        imd_write({4'($urandom), $urandom, $urandom}, 2'b11);
        imd_write({4'($urandom), $urandom, $urandom}, 2'b00);

        // Directed vectors
        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].dit,
                   vecs[i].exp, vecs[i].en, 0, 0);

        // Writeback stall of 5 cycles after a MULL
        run_op(2'd0, 2'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b0, 32'hFFFFFFEB, 3, 5, 0);

        // Flush in IDLE suppresses the accept
        @(negedge clk_i);
        req_valid_i = 1; flush_i = 1; req_operator_i = 2'd0;
        @(posedge clk_i); #1;
        req_valid_i = 0; flush_i = 0;
        @(negedge clk_i);
        chk("idle_flush", {req_ready_o, mult_en_o, div_en_o}, 3'b100);

        // Flush on cycle 10 of a DIV: unit runs to completion, result dropped
        @(negedge clk_i);
        req_valid_i = 1; req_operator_i = 2'd2; req_signed_mode_i = 0;
        req_op_a_i = 100; req_op_b_i = 7; data_ind_timing_i = 0; req_rd_i = 5'd3;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        cyc = 0; en_seen = 0; saw_wb = 0;
        while (cyc < 60) begin
            @(negedge clk_i); cyc++;
            flush_i = (cyc == 10);
            if (div_en_o) en_seen++;
            if (wb_valid_o) saw_wb = 1;
            if (!div_en_o && req_ready_o) break;
        end
        flush_i = 0;
        chk("flush_en_cycles", en_seen, 37);
        chk("flush_no_wb", saw_wb, 0);
        chk("flush_to_idle", cyc, 38);
        run_op(2'd0, 2'd0, 32'd3, 32'd4, 5'd4, 1'b0, 32'd12, 3, 0, 0);

        // Flush while waiting in WB drops the handshake
        run_op(2'd1, 2'd1, 32'hFFFFFFFF, 32'd2, 5'd5, 1'b0, 32'hFFFFFFFF, 4, 2, 1);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rsm  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            rdit = 1'($urandom_range(0, 1));
            run_op(rop, rsm, ra, rb, 5'($urandom), rdit, ref_result(rop, rsm, ra, rb),
                   ref_lat(rop, rb, rdit), $urandom_range(0, 2), 0);
        end

        // Reset in the middle of a DIV, with an imd write made during BUSY
        @(negedge clk_i);
        req_valid_i = 1; req_operator_i = 2'd2; req_op_a_i = 32'd50; req_op_b_i = 32'd3;
        @(posedge clk_i); #1;
        req_valid_i = 0;
        imd_write({4'hA, $urandom, $urandom}, 2'b11);
        chk("busy_before_rst", div_en_o, 1);
        @(negedge clk_i);
        rst_ni = 0; #1;
        chk("mid_rst_ctl", {req_ready_o, div_en_o, div_sel_o, multdiv_ready_id_o, wb_valid_o}, 5'b10000);
        chk("mid_rst_held", {op_a_o, op_b_o, operator_o}, 66'd0);
        chk("mid_rst_imd", imd_val_q_o, 68'd0);
        imd_m = '0;
        @(negedge clk_i);
        rst_ni = 1;
        run_op(2'd0, 2'd3, 32'hFFFFFFFF, 32'd5, 5'd31, 1'b0, 32'hFFFFFFFB, 3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
